calendar_counter: RTL and testbench
===================================

# calendar_counter

Time-of-day and date register bank for the century clock, sitting directly downstream of the setting control unit. Advances seconds through years on a 1 Hz tick with full Gregorian month lengths for 2000–2099, and applies the per-field up/down adjust requests produced by the control unit without carrying into neighbouring fields. Its outputs feed the display/blink path.

## Interface
- No parameters. Century fixed at 2000–2099; year field holds 0–99.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-`clk`-cycle pulse, once per second.
- `run` in 1: 1 = time advances on `tick_1hz`; 0 = counting frozen (setting mode).
- `up_s`, `down_s`, `up_m`, `down_m`, `up_h`, `down_h` in 1 each: adjust levels for second, minute, hour.
- `up_d`, `down_d`, `up_mo`, `down_mo`, `up_y`, `down_y` in 1 each: adjust levels for day, month, year.
- `sec` out 6: 0–59.
- `min` out 6: 0–59.
- `hour` out 5: 0–23.
- `day` out 5: 1–28/29/30/31.
- `month` out 4: 1–12.
- `year` out 7: 0–99, meaning 2000+year.
- `century_wrap` out 1: one-cycle pulse when a tick rolls 99-12-31 23:59:59 to 00-01-01 00:00:00.

## Operation
- Reset: sec=0, min=0, hour=0, day=1, month=1, year=0, `century_wrap`=0, all internal edge-detect registers 0.
- Adjust inputs are levels. The block registers each one, and an action is a rising edge: input 1 this cycle, registered copy 0. A held button yields exactly one step.
- Days in month: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; February 29 when year[1:0]==0, else 28. Year 0 (2000) is a leap year.
- Counting, when `run`=1 and `tick_1hz`=1 and no adjust edge is present this cycle:
  - sec increments.
  - 59→0 carries into min; 59→0 carries into hour; 23→0 carries into day.
  - day past days-in-month → 1, carries into month.
  - 12→1 carries into year; 99→0 asserts `century_wrap`.
- Adjust, on a rising edge of one field's up or down:
  - That field alone steps ±1 and wraps within its own range: sec/min 0↔59, hour 0↔23, month 1↔12, year 0↔99.
  - Day wraps between 1 and the current days-in-month (down from 1 → days-in-month).
  - No carry or borrow into other fields.
- Day clamp: if a month or year adjust makes the current day exceed the new days-in-month, day is set to the new maximum on the same edge (e.g. 31 → 30, 29 → 28).
- Simultaneous events:
  - An adjust edge in a cycle with `tick_1hz` wins; that tick is discarded.
  - Up and down edges on the same field in the same cycle: no change.
  - Edges on several fields in one cycle: only the highest-priority field (sec > min > hour > day > month > year) is applied; the others are lost.
- Adjust edges are accepted regardless of `run`.
- Out-of-range states are unreachable from reset.

## Timing
- All outputs are registered and update on the `clk` edge that samples the causing event.
  - Tick at edge k → new values visible after edge k.
  - Adjust edge → field changed after the first edge that samples the input high.
- `century_wrap` is high for exactly the cycle following the wrapping edge.
- Full carry chain (sec through year) resolves in a single cycle; no multi-cycle ripple.
- `rst_n` assertion mid-operation forces reset values immediately and asynchronously. Deassertion is synchronised upstream; the first tick after release counts normally.
- Edge-detect registers cleared by reset: an input already high at reset release counts as a rising edge on the first clock.

## Test plan
- Full rollover: preload 2099-12-31 23:59:59 by adjusts, `run`=1, one tick → 2000-01-01 00:00:00 and `century_wrap` high for one cycle.
- Leap handling:
  - Year 24, 02-28 23:59:59, tick → 02-29.
  - Year 25, same starting time, tick → 03-01.
  - Year 0, 02-29 23:59:59, tick → 03-01.
- Held button: `up_m` high for 50 cycles at min=59 → min=0 exactly once, hour unchanged; `down_d` at day=1 in April → day=30.
- Clamp: day=31, month=3, `down_mo` pulse → month=2, day=29 (year 0) or 28 (year 1); month 1 → 12 on `down_mo`.
- Collision:
  - `tick_1hz` and `up_s` rising edge in the same cycle at sec=10 → sec=11 (one step only).
  - `up_h` and `down_h` edges together → hour unchanged.
  - `run`=0 with 5 ticks → no change.
- Reset mid-count: `rst_n` low for 1 cycle at an arbitrary time → 2000-01-01 00:00:00 immediately, `century_wrap`=0.

Source files
------------

// File: rtl/calendar_counter.sv
// Time-of-day and Gregorian date registers (2000-2099) with per-field adjust.
// Latency: one clk; ticks and adjust edges take effect on the sampling edge.
// No backpressure: ticks are accepted every cycle; an adjust edge discards a coincident tick.
module calendar_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       run,
    input  logic       up_s,
    input  logic       down_s,
    input  logic       up_m,
    input  logic       down_m,
    input  logic       up_h,
    input  logic       down_h,
    input  logic       up_d,
    input  logic       down_d,
    input  logic       up_mo,
    input  logic       down_mo,
    input  logic       up_y,
    input  logic       down_y,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [4:0] day,
    output logic [3:0] month,
    output logic [6:0] year,
    output logic       century_wrap
);

    // Field i owns bits {2i+1 = down, 2i = up}; index 0 (sec) has highest priority.
    logic [11:0] adj_dat;
    logic [11:0] adj_q;
    logic [11:0] adj_edge;
    logic [5:0]  fld_hit;

    logic [5:0] nxt_sec;
    logic [5:0] nxt_min;
    logic [4:0] nxt_hour;
    logic [4:0] nxt_day;
    logic [3:0] nxt_month;
    logic [6:0] nxt_year;
    logic       nxt_wrap;
    logic [4:0] dim_cur;
    logic [4:0] dim_new;

    assign adj_dat  = {down_y, up_y, down_mo, up_mo, down_d, up_d,
                       down_h, up_h, down_m, up_m, down_s, up_s};
    assign adj_edge = adj_dat & ~adj_q;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            fld_hit[i] = adj_edge[2*i] | adj_edge[2*i+1];
        end
    end

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        case (m)
            4'd2:                      return (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up) return (v == hi) ? lo : v + 7'd1;
        else    return (v == lo) ? hi : v - 7'd1;
    endfunction

    assign dim_cur = days_in_month(month, year);

    always_comb begin
        nxt_sec   = sec;
        nxt_min   = min;
        nxt_hour  = hour;
        nxt_day   = day;
        nxt_month = month;
        nxt_year  = year;
        nxt_wrap  = 1'b0;
        dim_new   = dim_cur;

        // Up and down together on the winning field cancel; lower fields are still dropped.
        if (fld_hit[0]) begin
            if (adj_edge[0] ^ adj_edge[1])
                nxt_sec = 6'(wrap_step({1'b0, sec}, 7'd0, 7'd59, adj_edge[0]));
        end else if (fld_hit[1]) begin
            if (adj_edge[2] ^ adj_edge[3])
                nxt_min = 6'(wrap_step({1'b0, min}, 7'd0, 7'd59, adj_edge[2]));
        end else if (fld_hit[2]) begin
            if (adj_edge[4] ^ adj_edge[5])
                nxt_hour = 5'(wrap_step({2'b0, hour}, 7'd0, 7'd23, adj_edge[4]));
        end else if (fld_hit[3]) begin
            if (adj_edge[6] ^ adj_edge[7])
                nxt_day = 5'(wrap_step({2'b0, day}, 7'd1, {2'b0, dim_cur}, adj_edge[6]));
        end else if (fld_hit[4]) begin
            if (adj_edge[8] ^ adj_edge[9]) begin
                nxt_month = 4'(wrap_step({3'b0, month}, 7'd1, 7'd12, adj_edge[8]));
                dim_new   = days_in_month(nxt_month, year);
                if (day > dim_new) nxt_day = dim_new;
            end
        end else if (fld_hit[5]) begin
            if (adj_edge[10] ^ adj_edge[11]) begin
                nxt_year = wrap_step(year, 7'd0, 7'd99, adj_edge[10]);
                dim_new  = days_in_month(month, nxt_year);
                if (day > dim_new) nxt_day = dim_new;
            end
        end else if (run && tick_1hz) begin
            if (sec != 6'd59) begin
                nxt_sec = sec + 6'd1;
            end else begin
                nxt_sec = 6'd0;
                if (min != 6'd59) begin
                    nxt_min = min + 6'd1;
                end else begin
                    nxt_min = 6'd0;
                    if (hour != 5'd23) begin
                        nxt_hour = hour + 5'd1;
                    end else begin
                        nxt_hour = 5'd0;
                        if (day != dim_cur) begin
                            nxt_day = day + 5'd1;
                        end else begin
                            nxt_day = 5'd1;
                            if (month != 4'd12) begin
                                nxt_month = month + 4'd1;
                            end else begin
                                nxt_month = 4'd1;
                                if (year != 7'd99) begin
                                    nxt_year = year + 7'd1;
                                end else begin
                                    nxt_year = 7'd0;
                                    nxt_wrap = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adj_q        <= '0;
            sec          <= 6'd0;
            min          <= 6'd0;
            hour         <= 5'd0;
            day          <= 5'd1;
            month        <= 4'd1;
            year         <= 7'd0;
            century_wrap <= 1'b0;
        end else begin
            adj_q        <= adj_dat;
            sec          <= nxt_sec;
            min          <= nxt_min;
            hour         <= nxt_hour;
            day          <= nxt_day;
            month        <= nxt_month;
            year         <= nxt_year;
            century_wrap <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: a behavioural calendar model queues expected state per cycle.
module tb_calendar_counter;

    localparam int US = 0, DS = 1, UM = 2, DM = 3, UH = 4, DH = 5;
    localparam int UD = 6, DD = 7, UMO = 8, DMO = 9, UY = 10, DY = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_1hz;
    logic        run;
    logic [11:0] adj;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [6:0]  year;
    logic        century_wrap;

    always #5 clk = ~clk;

    calendar_counter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .run          (run),
        .up_s         (adj[US]),
        .down_s       (adj[DS]),
        .up_m         (adj[UM]),
        .down_m       (adj[DM]),
        .up_h         (adj[UH]),
        .down_h       (adj[DH]),
        .up_d         (adj[UD]),
        .down_d       (adj[DD]),
        .up_mo        (adj[UMO]),
        .down_mo      (adj[DMO]),
        .up_y         (adj[UY]),
        .down_y       (adj[DY]),
        .sec          (sec),
        .min          (min),
        .hour         (hour),
        .day          (day),
        .month        (month),
        .year         (year),
        .century_wrap (century_wrap)
    );

    typedef struct {
        int s; int mn; int hr; int dy; int mo; int yr; int wrap;
    } exp_t;

    exp_t        sb[$];
    int          m_s, m_mn, m_hr, m_dy, m_mo, m_yr, m_wrap;
    logic [11:0] m_prev;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int mdim(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic model_reset();
        m_s = 0; m_mn = 0; m_hr = 0; m_dy = 1; m_mo = 1; m_yr = 0; m_wrap = 0;
        m_prev = '0;
    endtask

    task automatic model_step(input logic [11:0] a, input logic t, input logic r);
        logic [11:0] e;
        int f;
        logic up, dn;
        e = a & ~m_prev;
        m_prev = a;
        m_wrap = 0;
        f = -1;
        for (int i = 5; i >= 0; i--) if (e[2*i] || e[2*i+1]) f = i;
        if (f >= 0) begin
            up = e[2*f];
            dn = e[2*f+1];
            if (up != dn) begin
                case (f)
                    0: m_s  = up ? (m_s + 1) % 60  : (m_s + 59) % 60;
                    1: m_mn = up ? (m_mn + 1) % 60 : (m_mn + 59) % 60;
                    2: m_hr = up ? (m_hr + 1) % 24 : (m_hr + 23) % 24;
                    3: m_dy = up ? (m_dy % mdim(m_mo, m_yr)) + 1
                                 : (m_dy == 1 ? mdim(m_mo, m_yr) : m_dy - 1);
                    4: begin
                        m_mo = up ? (m_mo % 12) + 1 : (m_mo == 1 ? 12 : m_mo - 1);
                        if (m_dy > mdim(m_mo, m_yr)) m_dy = mdim(m_mo, m_yr);
                    end
                    default: begin
                        m_yr = up ? (m_yr + 1) % 100 : (m_yr + 99) % 100;
                        if (m_dy > mdim(m_mo, m_yr)) m_dy = mdim(m_mo, m_yr);
                    end
                endcase
            end
        end else if (t && r) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0; m_mn++;
                if (m_mn == 60) begin
                    m_mn = 0; m_hr++;
                    if (m_hr == 24) begin
                        m_hr = 0; m_dy++;
                        if (m_dy > mdim(m_mo, m_yr)) begin
                            m_dy = 1; m_mo++;
                            if (m_mo == 13) begin
                                m_mo = 1; m_yr++;
                                if (m_yr == 100) begin
                                    m_yr = 0;
                                    m_wrap = 1;
                                end
                            end
                        end
                    end
                end
            end
        end
    endtask

    // One clock of stimulus: drive at negedge, queue the model's prediction, compare after the edge.
    task automatic step(input logic [11:0] a, input logic t, input logic r);
        exp_t x;
        @(negedge clk);
        adj = a;
        tick_1hz = t;
        run = r;
        model_step(a, t, r);
        x.s = m_s; x.mn = m_mn; x.hr = m_hr; x.dy = m_dy; x.mo = m_mo; x.yr = m_yr; x.wrap = m_wrap;
        sb.push_back(x);
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        if (sb.size() == 0) begin
            check_val("sb_underflow", 0, 1);
        end else begin
            x = sb.pop_front();
            check_val("sb_sec",   sec,          x.s);
            check_val("sb_min",   min,          x.mn);
            check_val("sb_hour",  hour,         x.hr);
            check_val("sb_day",   day,          x.dy);
            check_val("sb_month", month,        x.mo);
            check_val("sb_year",  year,         x.yr);
            check_val("sb_wrap",  century_wrap, x.wrap);
        end
    endtask

    task automatic pulse(input int b);
        logic [11:0] a;
        a = '0;
        a[b] = 1'b1;
        step(a, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
    endtask

    task automatic hms_max();
        pulse(DH);
        pulse(DM);
        pulse(DS);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_sec"},   sec,          0);
        check_val({tag, "_min"},   min,          0);
        check_val({tag, "_hour"},  hour,         0);
        check_val({tag, "_day"},   day,          1);
        check_val({tag, "_month"}, month,        1);
        check_val({tag, "_year"},  year,         0);
        check_val({tag, "_wrap"},  century_wrap, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick_1hz = 1'b0;
        run = 1'b0;
        adj = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Century rollover from 2099-12-31 23:59:59
        pulse(DY); pulse(DMO); pulse(DD);
        hms_max();
        check_val("pre_year", year, 99);
        check_val("pre_day",  day,  31);
        step('0, 1'b1, 1'b1);
        check_val("roll_wrap",  century_wrap, 1);
        check_val("roll_year",  year,  0);
        check_val("roll_month", month, 1);
        check_val("roll_day",   day,   1);
        check_val("roll_sec",   sec,   0);
        step('0, 1'b0, 1'b1);
        check_val("roll_wrap_drop", century_wrap, 0);

        // Leap year 2024: Feb 28 -> Feb 29
        repeat (24) pulse(UY);
        pulse(UMO); pulse(DD); pulse(DD);
        check_val("y24_day_set", day, 28);
        hms_max();
        step('0, 1'b1, 1'b1);
        check_val("y24_day",   day,   29);
        check_val("y24_month", month, 2);

        // 2025: clamp 29 -> 28 on year change, then Feb 28 -> Mar 1
        pulse(UY);
        check_val("y25_clamp", day, 28);
        hms_max();
        step('0, 1'b1, 1'b1);
        check_val("y25_day",   day,   1);
        check_val("y25_month", month, 3);

        // 2000: Feb 29 -> Mar 1
        pulse(DMO);
        repeat (25) pulse(DY);
        pulse(DD);
        check_val("y00_feb29", day, 29);
        hms_max();
        step('0, 1'b1, 1'b1);
        check_val("y00_day",   day,   1);
        check_val("y00_month", month, 3);

        // Held up_m at min 59 steps exactly once, no carry
        pulse(DM);
        repeat (50) step(12'(1) << UM, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check_val("held_min",  min,  0);
        check_val("held_hour", hour, 0);

        // down_d at day 1 in April
        pulse(UMO);
        pulse(DD);
        check_val("apr_day", day, 30);

        // Month clamp 31 -> 29 (year 0), 31 -> 28 (year 1), Jan -> Dec
        pulse(DMO); pulse(UD);
        check_val("mar_31", day, 31);
        pulse(DMO);
        check_val("clamp_mo0",  month, 2);
        check_val("clamp_day0", day,   29);
        pulse(UMO); pulse(UD); pulse(UD); pulse(UY);
        pulse(DMO);
        check_val("clamp_day1", day, 28);
        pulse(DMO); pulse(DMO);
        check_val("mo_wrap_dn", month, 12);

        // Collisions
        repeat (10) pulse(US);
        step(12'(1) << US, 1'b1, 1'b1);
        check_val("tick_adj_sec", sec, 11);
        step('0, 1'b0, 1'b0);
        step((12'(1) << UH) | (12'(1) << DH), 1'b0, 1'b0);
        check_val("updn_hour", hour, 0);
        step('0, 1'b0, 1'b0);
        step((12'(1) << US) | (12'(1) << UM), 1'b0, 1'b0);
        check_val("prio_sec", sec, 12);
        check_val("prio_min", min, 0);
        step('0, 1'b0, 1'b0);
        repeat (5) step('0, 1'b1, 1'b0);
        check_val("frozen_sec", sec, 12);

        // Mid-count async reset; up_s held high across release counts as an edge
        repeat (3) step('0, 1'b1, 1'b1);
        check_val("count_sec", sec, 15);
        #2 rst_n = 1'b0;
        adj = 12'(1) << US;
        run = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(12'(1) << US, 1'b0, 1'b0);
        check_val("rel_edge_sec", sec, 1);
        step('0, 1'b1, 1'b1);
        check_val("rel_tick_sec", sec, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
